// File: rtl/wb_queue_ctrl.sv
// Write-back queue controller: decodes write requests from the instruction stream and
// buffers the selected source word in a small FIFO that drains to a memory write port.

package wb_queue_defs_pkg;
  typedef enum logic [8:0] {
    NOP = 9'h000,
    PSH = 9'h101,
    POP = 9'h102,
    MVR = 9'h103,
    MVL = 9'h104,
    INC = 9'h105,
    DEC = 9'h106,
    JMP = 9'h107
  } op_code;
endpackage

module wb_queue_ctrl
  import wb_queue_defs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_SRC  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8:0]                 instruction,
  input  logic                       instr_valid,
  input  logic                       pop_bubble,
  input  logic                       flush,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  input  logic                       mem_ready,
  output logic                       mem_wr_en,
  output logic [DATA_W-1:0]          mem_wr_data,
  output logic                       stall,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a word leaves the queue on any edge where mem_wr_en and mem_ready are
  // both high; mem_wr_en never depends combinationally on mem_ready.

  op_code              op;
  logic                src_sel;
  logic                wreq;
  logic [DATA_W-1:0]   wdata;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_next;
  logic [AW-1:0]       wr_next;
  logic [CW-1:0]       count_next;
  logic [DATA_W-1:0]   head_next;

  assign op = op_code'(instruction);

  always_comb begin
    src_sel = 1'b0;
    wreq    = 1'b0;
    if (pop_bubble) begin
      src_sel = 1'b0;
      wreq    = 1'b1;
    end else begin
      src_sel = (op == PSH) || (op == MVL);
      wreq    = instr_valid &&
                ((op == POP) || (op == MVR) || (op == MVL) || (op == INC) || (op == DEC));
    end
  end

  assign wdata = src_sel ? src_data[DATA_W +: DATA_W] : src_data[0 +: DATA_W];

  // Words 2 and up are reserved for future modes.
  if (N_SRC > 2) begin : g_spare_src
    logic unused_src_hi;
    assign unused_src_hi = ^src_data[N_SRC*DATA_W-1:2*DATA_W];
  end

  assign full = (count == CW'(DEPTH));
  assign pop  = mem_wr_en & mem_ready;
  assign push = wreq & (~full | pop) & ~flush;
  assign drop = wreq & full & ~pop & ~flush;

  always_comb begin
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    count_next = count;
    if (flush) begin
      rd_next    = '0;
      wr_next    = '0;
      count_next = '0;
    end else begin
      if (pop)  rd_next = rd_ptr + AW'(1);
      if (push) wr_next = wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // The head after this edge is the incoming word when it lands where the read pointer
  // is about to point (empty queue, or push+pop at a single entry).
  always_comb begin
    head_next = mem[rd_next];
    if (push && (wr_ptr == rd_next)) head_next = wdata;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      mem_wr_en    <= 1'b0;
      stall        <= 1'b0;
      mem_wr_data  <= '0;
      overflow_err <= 1'b0;
    end else begin
      rd_ptr      <= rd_next;
      wr_ptr      <= wr_next;
      count       <= count_next;
      mem_wr_en   <= (count_next != '0);
      stall       <= (count_next == CW'(DEPTH));
      mem_wr_data <= head_next;
      if (drop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_queue_ctrl.sv
// Bench for wb_queue_ctrl: per-cycle vector table for status outputs, plus a scoreboard
// queue that checks every word written to memory, and a hand-written async reset sequence.

module tb_wb_queue_ctrl;
  import wb_queue_defs_pkg::*;

  localparam int DATA_W = 8;
  localparam int N_SRC  = 2;
  localparam int DEPTH  = 4;

  logic                     clk;
  logic                     rst_n;
  logic [8:0]               instruction;
  logic                     instr_valid;
  logic                     pop_bubble;
  logic                     flush;
  logic [N_SRC*DATA_W-1:0]  src_data;
  logic                     mem_ready;
  logic                     mem_wr_en;
  logic [DATA_W-1:0]        mem_wr_data;
  logic                     stall;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow_err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_word;

  typedef struct {
    string       name;
    logic        valid;
    logic        bubble;
    logic        flush;
    logic        ready;
    logic [8:0]  instr;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic        push;
    logic [7:0]  pdata;
    logic [2:0]  cnt;
    logic        en;
    logic        stl;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  wb_queue_ctrl #(.DATA_W(DATA_W), .N_SRC(N_SRC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pop_bubble   (pop_bubble),
    .flush        (flush),
    .src_data     (src_data),
    .mem_ready    (mem_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .stall        (stall),
    .count        (count),
    .overflow_err (overflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // scoreboard: every accepted memory write must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && mem_wr_en && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain: unexpected write of 0x%0h with empty expected queue", mem_wr_data);
      end else begin
        exp_word = exp_q.pop_front();
        check("drain_data", 32'(mem_wr_data), 32'(exp_word));
      end
    end
  end

  function automatic vec_t mk(input string nm, input logic v, input logic b, input logic f,
                              input logic r, input logic [8:0] ins, input logic [7:0] w0,
                              input logic [7:0] w1, input logic p, input logic [7:0] pd,
                              input logic [2:0] c, input logic e, input logic s,
                              input logic o);
    vec_t t;
    t.name = nm; t.valid = v; t.bubble = b; t.flush = f; t.ready = r;
    t.instr = ins; t.w0 = w0; t.w1 = w1; t.push = p; t.pdata = pd;
    t.cnt = c; t.en = e; t.stl = s; t.ovf = o;
    return t;
  endfunction

  // driver: apply one cycle of inputs, then check status just after the edge
  task automatic apply(input vec_t v, input int idx);
    instr_valid = v.valid;
    pop_bubble  = v.bubble;
    flush       = v.flush;
    mem_ready   = v.ready;
    instruction = v.instr;
    src_data    = {v.w1, v.w0};
    if (v.flush) exp_q.delete();
    if (v.push) exp_q.push_back(v.pdata);
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d].count", v.name, idx), 32'(count), 32'(v.cnt));
    check($sformatf("%s[%0d].mem_wr_en", v.name, idx), 32'(mem_wr_en), 32'(v.en));
    check($sformatf("%s[%0d].stall", v.name, idx), 32'(stall), 32'(v.stl));
    check($sformatf("%s[%0d].overflow_err", v.name, idx), 32'(overflow_err), 32'(v.ovf));
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = NOP;
    instr_valid = 1'b0;
    pop_bubble  = 1'b0;
    flush       = 1'b0;
    src_data    = '0;
    mem_ready   = 1'b0;

    // name, valid, bubble, flush, ready, instr, w0, w1, push, pdata, cnt, en, stall, ovf
    tbl.push_back(mk("single_inc",   1, 0, 0, 1, INC, 8'h5A, 8'h00, 1, 8'h5A, 1, 1, 0, 0));
    tbl.push_back(mk("single_drain", 0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk("psh_nowrite",  1, 0, 0, 0, PSH, 8'h11, 8'h33, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk("mvl_src1",     1, 0, 0, 0, MVL, 8'h11, 8'h33, 1, 8'h33, 1, 1, 0, 0));
    tbl.push_back(mk("mvr_src0",     1, 0, 0, 0, MVR, 8'h44, 8'h99, 1, 8'h44, 2, 1, 0, 0));
    tbl.push_back(mk("psh_invalid",  0, 0, 0, 1, PSH, 8'h11, 8'h33, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk("nop_drain",    1, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk("jmp_nowrite",  1, 0, 0, 0, JMP, 8'h66, 8'h66, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk("empty_ready",  0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk("fill_a", 1, 0, 0, 0, POP, 8'(i), 8'h00, 1, 8'(i), 3'(i), 1, (i == 4), 0));
    tbl.push_back(mk("full_pushpop", 1, 0, 0, 1, DEC, 8'h09, 8'h00, 1, 8'h09, 4, 1, 1, 0));
    for (int i = 3; i >= 0; i--)
      tbl.push_back(mk("drain_a", 0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 3'(i), (i != 0), 0, 0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk("fill_b", 1, 0, 0, 0, POP, 8'(i), 8'h00, 1, 8'(i), 3'(i), 1, (i == 4), 0));
    tbl.push_back(mk("overflow",     1, 0, 0, 0, POP, 8'h05, 8'h00, 0, 8'h00, 4, 1, 1, 1));
    for (int i = 3; i >= 0; i--)
      tbl.push_back(mk("drain_b", 0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 3'(i), (i != 0), 0, 1));
    tbl.push_back(mk("bubble",       0, 1, 0, 0, NOP, 8'h77, 8'h00, 1, 8'h77, 1, 1, 0, 1));
    tbl.push_back(mk("flush_push",   1, 0, 1, 0, INC, 8'hAA, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk("after_flush",  0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk("bubble_ovr",   1, 1, 0, 0, MVL, 8'h12, 8'h34, 1, 8'h12, 1, 1, 0, 1));
    tbl.push_back(mk("c1_pushpop",   1, 0, 0, 1, INC, 8'h56, 8'h00, 1, 8'h56, 1, 1, 0, 1));
    tbl.push_back(mk("c1_drain",     0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1));

    #3;
    check("reset.count", 32'(count), 0);
    check("reset.mem_wr_en", 32'(mem_wr_en), 0);
    check("reset.stall", 32'(stall), 0);
    check("reset.overflow_err", 32'(overflow_err), 0);
    check("reset.mem_wr_data", 32'(mem_wr_data), 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], i);

    // async reset with three entries queued, asserted between clock edges
    for (int i = 1; i <= 3; i++)
      apply(mk("rst_fill", 1, 0, 0, 0, INC, 8'(8'hA0 + i), 8'h00, 1, 8'(8'hA0 + i),
               3'(i), 1, 0, 1), i);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.count", 32'(count), 0);
    check("async_rst.mem_wr_en", 32'(mem_wr_en), 0);
    check("async_rst.stall", 32'(stall), 0);
    check("async_rst.overflow_err", 32'(overflow_err), 0);
    check("async_rst.mem_wr_data", 32'(mem_wr_data), 0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(mk("post_rst_idle", 0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0), i);
    apply(mk("post_rst_push", 1, 0, 0, 1, INC, 8'hC3, 8'h00, 1, 8'hC3, 1, 1, 0, 0), 0);
    apply(mk("post_rst_drain", 0, 0, 0, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0), 0);

    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
